// File: rtl/ln_stage1_ctrl.sv
// LayerNorm stage-1 sequencer: issues row beats to the accumulate stage and sums the
// delayed partial sums per slot, releasing finished rows in issue order.
module ln_stage1_ctrl #(
    parameter int BEATS_PER_ROW = 12,
    parameter int NUM_SLOTS     = 4,
    parameter int PSUM_W        = 22,
    parameter int PSQ_W         = 38
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     o_st_valid,
    output logic [1:0]               o_st_ptr,
    output logic [3:0]               o_st_cnt,
    input  logic                     i_acc_valid,
    input  logic [1:0]               i_acc_ptr,
    input  logic [3:0]               i_acc_cnt,
    input  logic signed [PSUM_W-1:0] i_part_sum,
    input  logic signed [PSQ_W-1:0]  i_part_sq_sum,
    output logic                     o_row_valid,
    input  logic                     i_row_ready,
    output logic [1:0]               o_row_ptr,
    output logic signed [PSUM_W+3:0] o_row_sum,
    output logic signed [PSQ_W+3:0]  o_row_sq_sum,
    output logic                     o_err
);

    localparam int SUM_W = PSUM_W + 4;
    localparam int SQ_W  = PSQ_W + 4;
    localparam logic [3:0] LAST_CNT = 4'(BEATS_PER_ROW - 1);

    typedef enum logic {IDLE, ROW} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [1:0]              r_wr_ptr;
    logic [1:0]              r_rd_ptr;
    logic [NUM_SLOTS-1:0]    r_busy;
    logic [NUM_SLOTS-1:0]    r_done;
    logic                    r_err;
    logic signed [SUM_W-1:0] r_acc_sum [NUM_SLOTS];
    logic signed [SQ_W-1:0]  r_acc_sq  [NUM_SLOTS];

    logic                    w_accept;
    logic                    w_last;
    logic                    w_pop;
    logic                    w_acc_fire;
    logic                    w_err_cond;
    logic                    w_acc_wr;
    logic [NUM_SLOTS-1:0]    w_busy_set;
    logic [NUM_SLOTS-1:0]    w_done_set;
    logic [NUM_SLOTS-1:0]    w_pop_mask;
    logic signed [SUM_W-1:0] w_psum_ext;
    logic signed [SQ_W-1:0]  w_psq_ext;

    // A new row may only claim a slot whose registered busy flag is clear, so a slot
    // freed by an output pop becomes usable one cycle later.
    assign s_ready  = i_rst_n & i_en & ((r_state == ROW) | ~r_busy[r_wr_ptr]);
    assign w_accept = s_valid & s_ready;
    assign w_last   = (r_cnt == LAST_CNT);

    assign o_st_valid = w_accept;
    assign o_st_ptr   = r_wr_ptr;
    assign o_st_cnt   = r_cnt;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_last) w_state_nxt = ROW;
            ROW:     if (w_accept && w_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (w_last) begin
                    r_cnt    <= '0;
                    r_wr_ptr <= r_wr_ptr + 2'd1;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    // Stage-1 outputs are frozen while i_en is low, so only enabled cycles may consume them.
    assign w_acc_fire = i_en & i_acc_valid;
    assign w_err_cond = w_acc_fire & (~r_busy[i_acc_ptr] | r_done[i_acc_ptr] |
                                      (int'(i_acc_cnt) >= BEATS_PER_ROW));
    assign w_acc_wr   = w_acc_fire & ~w_err_cond;
    assign w_psum_ext = SUM_W'(i_part_sum);
    assign w_psq_ext  = SQ_W'(i_part_sq_sum);

    assign w_pop      = r_done[r_rd_ptr] & i_row_ready;
    assign w_pop_mask = w_pop ? (NUM_SLOTS'(1) << r_rd_ptr) : '0;
    assign w_busy_set = (w_accept && (r_state == IDLE)) ? (NUM_SLOTS'(1) << r_wr_ptr) : '0;
    assign w_done_set = (w_acc_wr && (i_acc_cnt == LAST_CNT)) ? (NUM_SLOTS'(1) << i_acc_ptr) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= '0;
            r_done   <= '0;
            r_rd_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_pop_mask) | w_busy_set;
            r_done <= (r_done & ~w_pop_mask) | w_done_set;
            r_err  <= r_err | w_err_cond;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
        end
    end

    // NOTE: the accumulator array is small and drives o_row_* directly, so it is reset to
    // give defined outputs after reset; large RAM-style arrays would normally not be reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_acc_sum[i] <= '0;
                r_acc_sq[i]  <= '0;
            end
        end else if (w_acc_wr) begin
            if (i_acc_cnt == 4'd0) begin
                r_acc_sum[i_acc_ptr] <= w_psum_ext;
                r_acc_sq[i_acc_ptr]  <= w_psq_ext;
            end else begin
                r_acc_sum[i_acc_ptr] <= r_acc_sum[i_acc_ptr] + w_psum_ext;
                r_acc_sq[i_acc_ptr]  <= r_acc_sq[i_acc_ptr] + w_psq_ext;
            end
        end
    end

    assign o_row_valid  = r_done[r_rd_ptr];
    assign o_row_ptr    = r_rd_ptr;
    assign o_row_sum    = r_acc_sum[r_rd_ptr];
    assign o_row_sq_sum = r_acc_sq[r_rd_ptr];
    assign o_err        = r_err;

endmodule

// File: tb/tb_ln_stage1_ctrl.sv
// Bench for ln_stage1_ctrl: a 7-deep stage-1 stand-in feeds partial sums back, and a
// row-level queue model predicts handshakes, pointers and finished-row sums every cycle.
module tb_ln_stage1_ctrl;

    localparam int BEATS  = 12;
    localparam int PSUM_W = 22;
    localparam int PSQ_W  = 38;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_en = 1'b1;
    logic s_valid = 1'b0;
    logic i_row_ready = 1'b1;
    logic s_ready, o_st_valid, o_row_valid, o_err;
    logic [1:0] o_st_ptr, o_row_ptr;
    logic [3:0] o_st_cnt;
    logic signed [PSUM_W+3:0] o_row_sum;
    logic signed [PSQ_W+3:0]  o_row_sq_sum;
    logic i_acc_valid;
    logic [1:0] i_acc_ptr;
    logic [3:0] i_acc_cnt;
    logic signed [PSUM_W-1:0] i_part_sum;
    logic signed [PSQ_W-1:0]  i_part_sq_sum;

    logic signed [PSUM_W-1:0] tb_psum = '0;
    logic signed [PSQ_W-1:0]  tb_psq = '0;
    logic inj = 1'b0;
    logic [1:0] inj_ptr = '0;
    logic [3:0] inj_cnt = '0;
    int en_mode = 0;
    int rdy_mode = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int last_acc_cyc = 0;
    logic [1:0] pop_log [$];

    ln_stage1_ctrl #(.BEATS_PER_ROW(BEATS), .NUM_SLOTS(4), .PSUM_W(PSUM_W), .PSQ_W(PSQ_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .s_valid(s_valid), .s_ready(s_ready),
        .o_st_valid(o_st_valid), .o_st_ptr(o_st_ptr), .o_st_cnt(o_st_cnt),
        .i_acc_valid(i_acc_valid), .i_acc_ptr(i_acc_ptr), .i_acc_cnt(i_acc_cnt),
        .i_part_sum(i_part_sum), .i_part_sq_sum(i_part_sq_sum),
        .o_row_valid(o_row_valid), .i_row_ready(i_row_ready), .o_row_ptr(o_row_ptr),
        .o_row_sum(o_row_sum), .o_row_sq_sum(o_row_sq_sum), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    // Stage-1 stand-in: fixed 7-register pipe that only advances on enabled cycles.
    logic                     p_valid [7];
    logic [1:0]               p_ptr   [7];
    logic [3:0]               p_cnt   [7];
    logic signed [PSUM_W-1:0] p_sum   [7];
    logic signed [PSQ_W-1:0]  p_sq    [7];

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 7; i++) begin
                p_valid[i] <= 1'b0; p_ptr[i] <= '0; p_cnt[i] <= '0; p_sum[i] <= '0; p_sq[i] <= '0;
            end
        end else if (i_en) begin
            p_valid[0] <= o_st_valid; p_ptr[0] <= o_st_ptr; p_cnt[0] <= o_st_cnt;
            p_sum[0] <= tb_psum; p_sq[0] <= tb_psq;
            for (int i = 1; i < 7; i++) begin
                p_valid[i] <= p_valid[i-1]; p_ptr[i] <= p_ptr[i-1]; p_cnt[i] <= p_cnt[i-1];
                p_sum[i] <= p_sum[i-1]; p_sq[i] <= p_sq[i-1];
            end
        end
    end

    assign i_acc_valid   = inj ? 1'b1 : p_valid[6];
    assign i_acc_ptr     = inj ? inj_ptr : p_ptr[6];
    assign i_acc_cnt     = inj ? inj_cnt : p_cnt[6];
    assign i_part_sum    = inj ? '0 : p_sum[6];
    assign i_part_sq_sum = inj ? '0 : p_sq[6];

    // Enable and row-ready drivers: 0 = held high, 1 = random, 2 = held low.
    initial begin
        forever begin
            @(posedge i_clk);
            #2;
            i_en        = (en_mode == 0) ? 1'b1 : (en_mode == 2) ? 1'b0 : ($urandom_range(0, 4) != 0);
            i_row_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 1) != 0);
        end
    end

    // Row-level reference model: a FIFO of rows, each finished 7 enabled cycles after its
    // last beat's enabled cycle; at most 4 rows occupy slots at once.
    typedef struct {
        logic signed [PSUM_W+3:0] sum;
        logic signed [PSQ_W+3:0]  sq;
        int                       last_en;
        bit                       closed;
    } row_t;

    row_t       m_q [$];
    bit         m_in_row = 1'b0;
    int         m_beat = 0;
    logic [1:0] m_wr = '0;
    logic [1:0] m_rd = '0;
    bit         m_err = 1'b0;
    int         en_cycles = 0;

    function automatic bit m_front_ready();
        return (m_q.size() > 0) && m_q[0].closed && (en_cycles >= m_q[0].last_en + 7);
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_q.delete(); m_in_row = 1'b0; m_beat = 0; m_wr = '0; m_rd = '0; m_err = 1'b0;
        end else begin
            bit rdy_v, acc, pop;
            row_t nr;
            int idx;
            rdy_v = i_en && (m_in_row || m_q.size() < 4);
            acc   = s_valid && rdy_v;
            pop   = m_front_ready() && i_row_ready;
            if (i_en && inj) m_err = 1'b1;
            if (i_en) en_cycles++;
            if (pop) begin
                void'(m_q.pop_front());
                m_rd = m_rd + 2'd1;
            end
            if (acc) begin
                if (!m_in_row) begin
                    nr.sum = '0; nr.sq = '0; nr.last_en = 0; nr.closed = 1'b0;
                    m_q.push_back(nr);
                    m_in_row = 1'b1;
                end
                idx = m_q.size() - 1;
                m_q[idx].sum = m_q[idx].sum + 26'(tb_psum);
                m_q[idx].sq  = m_q[idx].sq + 42'(tb_psq);
                m_beat++;
                if (m_beat == BEATS) begin
                    m_q[idx].closed  = 1'b1;
                    m_q[idx].last_en = en_cycles;
                    m_in_row = 1'b0;
                    m_beat = 0;
                    m_wr = m_wr + 2'd1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge i_clk) begin
        bit exp_ready, exp_rv;
        exp_ready = i_rst_n && i_en && (m_in_row || m_q.size() < 4);
        exp_rv    = i_rst_n && m_front_ready();
        check("s_ready", 64'(s_ready), 64'(exp_ready));
        check("st_valid", 64'(o_st_valid), 64'(s_valid && exp_ready));
        check("st_ptr", 64'(o_st_ptr), 64'(m_wr));
        check("st_cnt", 64'(o_st_cnt), 64'(m_beat));
        check("row_valid", 64'(o_row_valid), 64'(exp_rv));
        check("row_ptr", 64'(o_row_ptr), 64'(m_rd));
        check("err", 64'(o_err), 64'(m_err));
        if (exp_rv) begin
            check("row_sum", 64'(o_row_sum), 64'(m_q[0].sum));
            check("row_sq_sum", 64'(o_row_sq_sum), 64'(m_q[0].sq));
        end
        if (i_rst_n && o_row_valid && i_row_ready) pop_log.push_back(o_row_ptr);
    end

    // kind: 0 = all elems +1, 1 = all elems -1, 2 = random partial sums.
    task automatic send_row(input int kind, input int gap_beat, input int n_beats, output int first_wait);
        first_wait = 0;
        for (int b = 0; b < n_beats; b++) begin
            int waited;
            bit got;
            if (b == gap_beat) begin
                s_valid = 1'b0;
                en_mode = 2;
                repeat (4) @(posedge i_clk);
                #1;
                en_mode = 0;
            end
            case (kind)
                0: begin tb_psum = 22'sd64;  tb_psq = 38'sd64; end
                1: begin tb_psum = -22'sd64; tb_psq = 38'sd64; end
                default: begin tb_psum = 22'($urandom); tb_psq = 38'({$urandom, $urandom}); end
            endcase
            s_valid = 1'b1;
            waited = 0;
            got = 1'b0;
            while (!got) begin
                @(negedge i_clk);
                got = s_valid && s_ready;
                if (got) last_acc_cyc = cyc;
                @(posedge i_clk);
                #1;
                if (!got) waited++;
                if (waited > 300) begin
                    check("beat_accept_timeout", 64'(waited), 64'(0));
                    got = 1'b1;
                end
            end
            if (b == 0) first_wait = waited;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_row(input string name, output logic signed [PSUM_W+3:0] sum,
                            output logic signed [PSQ_W+3:0] sq, output logic [1:0] ptr, output int at);
        bit seen = 1'b0;
        sum = '0; sq = '0; ptr = '0; at = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge i_clk);
            if (o_row_valid) begin
                seen = 1'b1; sum = o_row_sum; sq = o_row_sq_sum; ptr = o_row_ptr; at = cyc;
            end
        end
        if (!seen) check({name, "_timeout"}, 64'(0), 64'(1));
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        int i = 0;
        while (m_q.size() != 0 && i < 400) begin
            @(posedge i_clk);
            i++;
        end
        if (m_q.size() != 0) check("drain_timeout", 64'(m_q.size()), 64'(0));
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input bit check_now);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        if (check_now) begin
            check("rst_s_ready", 64'(s_ready), 64'(0));
            check("rst_st_ptr", 64'(o_st_ptr), 64'(0));
            check("rst_st_cnt", 64'(o_st_cnt), 64'(0));
            check("rst_row_valid", 64'(o_row_valid), 64'(0));
            check("rst_row_ptr", 64'(o_row_ptr), 64'(0));
            check("rst_row_sum", 64'(o_row_sum), 64'(0));
            check("rst_row_sq_sum", 64'(o_row_sq_sum), 64'(0));
            check("rst_err", 64'(o_err), 64'(0));
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [PSUM_W+3:0] sum;
        logic signed [PSQ_W+3:0]  sq;
        logic [1:0] ptr;
        int at, fw;
        logic [1:0] exp_order [5];
        exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
        exp_order[3] = 2'd3; exp_order[4] = 2'd0;

        // Reset state with enable already high.
        #3;
        check("init_s_ready", 64'(s_ready), 64'(0));
        check("init_err", 64'(o_err), 64'(0));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // One row of +1 elements: 768 / 768, slot 0, visible 8 cycles after the last beat.
        send_row(0, -1, BEATS, fw);
        wait_row("ones", sum, sq, ptr, at);
        check("ones_sum", 64'(sum), 64'(768));
        check("ones_sq_sum", 64'(sq), 64'(768));
        check("ones_ptr", 64'(ptr), 64'(0));
        check("ones_latency", 64'(at - last_acc_cyc), 64'(8));

        // One row of -1 elements: sum -768 (26-bit 0x3FFFD00), sq-sum 768, slot 1.
        send_row(1, -1, BEATS, fw);
        wait_row("neg", sum, sq, ptr, at);
        check("neg_sum_hex", 64'($unsigned(sum)), 64'h3FFFD00);
        check("neg_sq_sum", 64'(sq), 64'(768));
        check("neg_ptr", 64'(ptr), 64'(1));
        drain();

        // Five rows with stage 2 stalled: fifth row waits for a pop of slot 0.
        do_reset(1'b0);
        rdy_mode = 2;
        pop_log.delete();
        for (int r = 0; r < 4; r++) send_row(2, -1, BEATS, fw);
        s_valid = 1'b1;
        repeat (20) @(posedge i_clk);
        @(negedge i_clk);
        check("full_block", 64'(s_ready), 64'(0));
        @(posedge i_clk);
        #1;
        s_valid = 1'b0;
        rdy_mode = 0;
        @(negedge i_clk);
        check("full_pop_valid", 64'(o_row_valid), 64'(1));
        check("full_pop_ptr", 64'(o_row_ptr), 64'(0));
        check("full_pop_not_ready", 64'(s_ready), 64'(0));
        @(posedge i_clk);
        #1;
        rdy_mode = 2;
        send_row(2, -1, BEATS, fw);
        check("slot_reuse_next_cycle", 64'(fw), 64'(0));
        rdy_mode = 0;
        drain();
        check("order_count", 64'(pop_log.size()), 64'(5));
        for (int i = 0; i < 5 && i < pop_log.size(); i++)
            check("order_ptr", 64'(pop_log[i]), 64'(exp_order[i]));

        // Enable dropped mid-row and again while partial sums are returning.
        send_row(0, 5, BEATS, fw);
        repeat (3) @(posedge i_clk);
        #1;
        en_mode = 2;
        repeat (3) @(posedge i_clk);
        #1;
        en_mode = 0;
        wait_row("en_gap", sum, sq, ptr, at);
        check("en_gap_sum", 64'(sum), 64'(768));
        check("en_gap_sq_sum", 64'(sq), 64'(768));
        check("en_gap_err", 64'(o_err), 64'(0));
        drain();

        // Random data with random enable and output backpressure.
        en_mode = 1;
        rdy_mode = 1;
        for (int r = 0; r < 10; r++) send_row(2, -1, BEATS, fw);
        en_mode = 0;
        rdy_mode = 0;
        drain();

        // Reset in the middle of a row, then a clean row.
        send_row(0, -1, 5, fw);
        do_reset(1'b1);
        send_row(0, -1, BEATS, fw);
        wait_row("post_rst", sum, sq, ptr, at);
        check("post_rst_sum", 64'(sum), 64'(768));
        check("post_rst_sq_sum", 64'(sq), 64'(768));
        check("post_rst_ptr", 64'(ptr), 64'(0));
        drain();

        // Partial sum returned for an idle slot: sticky error until reset.
        inj_ptr = 2'd2;
        inj_cnt = 4'd0;
        inj = 1'b1;
        @(posedge i_clk);
        #1;
        inj = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        check("err_sticky", 64'(o_err), 64'(1));
        check("err_no_row", 64'(o_row_valid), 64'(0));
        do_reset(1'b0);
        @(negedge i_clk);
        check("err_cleared", 64'(o_err), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
